// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment bit positions, blank pattern and hex glyph table.
// Patterns are active-low (0 = segment lit), bit order {g,f,e,d,c,b,a} with dp above.
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low gfedcba segment pattern.
// Purely combinational; no flow control.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment scanner with per-frame input shadowing.
// Pins are registered one cycle after the scan state; no backpressure, inputs sampled once per frame.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    output logic [7:0]              seg_cat,
    output logic [NUM_DIGITS-1:0]   seg_an,
    output logic                    frame_tick
);
    import seg_pkg::*;

    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRESC_W-1:0] LAST_PRESC = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [PRESC_W-1:0] BLANK_END  = PRESC_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
    logic                    sh_lz_q, sh_lz_d;
    logic [7:0]              cat_q, cat_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    tick_q, tick_d;

    logic                    slot_end;
    logic                    frame_end;
    logic                    visible;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_hide;
    logic [3:0]              cur_hex;
    logic [6:0]              cur_seg;

    assign cur_hex = sh_val_q[{idx_q, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .hex_i (cur_hex),
        .seg_o (cur_seg)
    );

    // A digit is leading-zero blanked when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        zero_run = 1'b1;
        lz_hide  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run & (sh_val_q[4*i +: 4] == 4'h0);
            lz_hide[i] = sh_lz_q & zero_run & (i != 0);
        end
    end

    always_comb begin
        slot_end  = (presc_q == LAST_PRESC);
        frame_end = slot_end && (idx_q == LAST_IDX);

        presc_d = slot_end ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end

        sh_val_d = frame_end ? value    : sh_val_q;
        sh_dp_d  = frame_end ? dp       : sh_dp_q;
        sh_en_d  = frame_end ? digit_en : sh_en_q;
        sh_lz_d  = frame_end ? lz_blank : sh_lz_q;
        tick_d   = frame_end;

        visible = sh_en_q[idx_q] && !lz_hide[idx_q] && (presc_q >= BLANK_END);

        // Anode and cathodes come from the same state so they always change on the same edge.
        cat_d = SEG_BLANK;
        an_d  = '1;
        if (visible) begin
            an_d[idx_q]         = 1'b0;
            cat_d[SEG_G:SEG_A]  = cur_seg;
            cat_d[SEG_DP]       = ~sh_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            idx_q    <= '0;
            sh_val_q <= '0;
            sh_dp_q  <= '0;
            sh_en_q  <= '0;
            sh_lz_q  <= 1'b0;
            cat_q    <= SEG_BLANK;
            an_q     <= '1;
            tick_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            sh_val_q <= sh_val_d;
            sh_dp_q  <= sh_dp_d;
            sh_en_q  <= sh_en_d;
            sh_lz_q  <= sh_lz_d;
            cat_q    <= cat_d;
            an_q     <= an_d;
            tick_q   <= tick_d;
        end
    end

    assign seg_cat    = cat_q;
    assign seg_an     = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized and directed bench for seg_scan_driver (4 digits, 4-cycle slots, 1 blank cycle).
module tb_seg_scan_driver;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int BL    = 1;
    localparam int FRAME = ND * RD;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        lz;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic [7:0]  seg_cat;
    logic [3:0]  seg_an;
    logic        frame_tick;

    int    n_chk  = 0;
    int    n_pass = 0;
    int    n      = 0;
    snap_t snap_q[$];

    seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp         (dp),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .seg_cat    (seg_cat),
        .seg_an     (seg_an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b0100111;  4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n);
    endtask

    // Expected pins after n non-reset edges: they reflect scan position c = n-1 and the
    // snapshot taken at the start of the frame containing c (frame 0 is the dark reset shadow).
    task automatic expect_pins(output logic [3:0] an, output logic [7:0] cat, output logic tk);
        int    c, d, pos;
        snap_t s;
        an  = 4'hF;
        cat = 8'hFF;
        tk  = (n > 0) && (n % FRAME == 0);
        if (n > 0) begin
            c   = n - 1;
            s   = snap_q[c / FRAME];
            d   = (c / RD) % ND;
            pos = c % RD;
            if (s.en[d] && pos >= BL && !(s.lz && d != 0 && (s.v >> (4 * d)) == 16'h0)) begin
                an  = ~(4'b0001 << d);
                cat = {~s.dp[d], glyph(s.v[4*d +: 4])};
            end
        end
    endtask

    task automatic step();
        snap_t       s;
        logic [3:0]  e_an;
        logic [7:0]  e_cat;
        logic        e_tk;
        @(posedge clk);
        if (rst) begin
            n = 0;
            snap_q.delete();
            s.v = '0; s.dp = '0; s.en = '0; s.lz = 1'b0;
            snap_q.push_back(s);
        end else begin
            n++;
            if (n % FRAME == 0) begin
                s.v = value; s.dp = dp; s.en = digit_en; s.lz = lz_blank;
                snap_q.push_back(s);
            end
        end
        @(negedge clk);
        expect_pins(e_an, e_cat, e_tk);
        chk("seg_an", 32'(seg_an), 32'(e_an));
        chk("seg_cat", 32'(seg_cat), 32'(e_cat));
        chk("frame_tick", 32'(frame_tick), 32'(e_tk));
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) step();
    endtask

    task automatic set_in(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e, input logic lz);
        value = v; dp = d; digit_en = e; lz_blank = lz;
    endtask

    initial begin
        rst = 1'b1;
        set_in(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        run(3);
        rst = 1'b0;

        set_in(16'h12AF, 4'h0, 4'hF, 1'b0);
        run(3 * FRAME);

        set_in(16'h0070, 4'h0, 4'hF, 1'b1);
        run(2 * FRAME);
        set_in(16'h0000, 4'h0, 4'hF, 1'b1);
        run(2 * FRAME);

        set_in(16'h1111, 4'h0, 4'hF, 1'b0);
        run(2 * FRAME + 6);
        value = 16'h2222;
        run(2 * FRAME + 4);

        set_in(16'($urandom), 4'b0100, 4'b1011, 1'b0);
        run(2 * FRAME);

        while (n % FRAME != 9) step();
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(2 * FRAME + 8);

        for (int it = 0; it < 30; it++) begin
            set_in(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                run(1);
                rst = 1'b0;
            end
            run($urandom_range(1, 24));
        end
        run(FRAME + 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
